spi_slave_reg_bridge: RTL and testbench

- Sits directly downstream of the SPI slave: consumes each received frame (rx_data/rx_done) and supplies the next transmit word (tx_data) to the slave's data_in.
- Turns SPI transactions (one ss-low window) into register-file accesses: first frame is a command, later frames are burst write data or burst read slots.
- Owns a small register file that is also readable and writable by local logic through a host port.

---
 rtl/spi_slave_reg_bridge_pkg.sv | 18 +
 rtl/spi_slave_reg_bridge_if.sv | 29 ++
 rtl/spi_slave_reg_bridge_reg_file.sv | 58 +++++
 rtl/spi_slave_reg_bridge.sv | 165 ++++++++++++++++
 tb/tb_spi_slave_reg_bridge.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_reg_bridge_pkg.sv
// Shared definitions for the SPI-to-register bridge: default widths,
// the idle/status word and the transaction state encoding.
package spi_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  // Command frame: MSB selects write (1) or read (0).
  localparam int CMD_WRITE_BIT = DATA_W_DEF - 1;
  localparam logic [DATA_W_DEF-1:0] STATUS_WORD_DEF = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

endpackage

// File: rtl/spi_slave_reg_bridge_if.sv
// Bundle of the SPI-slave-side and host-side signals of the bridge.
// slave modport: the bridge itself; master modport: whoever drives it.
interface spi_slave_reg_bridge_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);

  logic              ss;
  logic [DATA_W-1:0] rx_data;
  logic              rx_done;
  logic [DATA_W-1:0] tx_data;
  logic [ADDR_W-1:0] host_addr;
  logic              host_we;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              spi_wr_strobe;
  logic [ADDR_W-1:0] spi_wr_addr;

  modport slave (
    input  ss, rx_data, rx_done, host_addr, host_we, host_wdata,
    output tx_data, host_rdata, spi_wr_strobe, spi_wr_addr
  );

  modport master (
    output ss, rx_data, rx_done, host_addr, host_we, host_wdata,
    input  tx_data, host_rdata, spi_wr_strobe, spi_wr_addr
  );

endinterface

// File: rtl/spi_slave_reg_bridge_reg_file.sv
// Register file with two write ports (SPI port wins on a same-address
// collision) and two asynchronous read ports. The SPI read port forwards
// a same-cycle host write so burst reads see the newest value.
module spi_reg_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_we_i,
  input  logic [ADDR_W-1:0] spi_addr_i,
  input  logic [DATA_W-1:0] spi_wdata_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [DATA_W-1:0] host_rdata_o
);

  localparam int REG_COUNT = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [REG_COUNT];

  // Storage: clear on reset, SPI write takes priority over host write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (spi_we_i && (spi_addr_i == ADDR_W'(i))) begin
          regs_q[i] <= spi_wdata_i;
        end else if (host_we_i && (host_addr_i == ADDR_W'(i))) begin
          regs_q[i] <= host_wdata_i;
        end else begin
          regs_q[i] <= regs_q[i];
        end
      end
    end
  end

  // SPI read port with write-first forwarding of a host write.
  always_comb begin
    if (host_we_i && (host_addr_i == rd_addr_i)) begin
      rd_data_o = host_wdata_i;
    end else begin
      rd_data_o = regs_q[rd_addr_i];
    end
  end

  // Host read port: plain view of the stored value.
  always_comb begin
    host_rdata_o = regs_q[host_addr_i];
  end

endmodule

// File: rtl/spi_slave_reg_bridge.sv
// Bridge between an SPI slave's frame interface and a small register file.
// The first frame of an ss-low window is a command; following frames are
// burst write data or burst read slots with an auto-incrementing pointer.
module spi_slave_reg_bridge
  import spi_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] STATUS_WORD = STATUS_WORD_DEF
) (
  input logic                  clk,
  input logic                  reset,
  spi_slave_reg_bridge_if.slave bus
);

  localparam int                CMD_BIT = DATA_W - 1;
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              rx_done_q;
  logic              ss_q;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              strobe_q, strobe_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              spi_we_s;
  logic              frame_evt_s;
  logic              ss_fall_s;
  logic              cmd_wr_s;
  logic [ADDR_W-1:0] cmd_addr_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [DATA_W-1:0] rd_data_s;

  assign frame_evt_s = bus.rx_done & ~rx_done_q;
  assign ss_fall_s   = ss_q & ~bus.ss;
  assign cmd_wr_s    = bus.rx_data[CMD_BIT];
  assign cmd_addr_s  = bus.rx_data[ADDR_W-1:0];
  // Read address is the command's start address in CMD, else the next slot.
  assign rd_addr_s   = (state_q == ST_CMD) ? cmd_addr_s : (ptr_q + PTR_ONE);

  // Edge-detect history for rx_done and ss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_done_q <= 1'b0;
      ss_q      <= 1'b1;
    end else begin
      rx_done_q <= bus.rx_done;
      ss_q      <= bus.ss;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; ss high always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (bus.ss) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ss_fall_s) state_d = ST_CMD;
          else           state_d = ST_IDLE;
        end
        ST_CMD: begin
          if (frame_evt_s) state_d = cmd_wr_s ? ST_WRITE : ST_READ;
          else             state_d = ST_CMD;
        end
        ST_WRITE: state_d = ST_WRITE;
        ST_READ:  state_d = ST_READ;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: pointer, MISO word, SPI write port and strobe.
  always_comb begin
    ptr_d    = ptr_q;
    tx_d     = tx_q;
    strobe_d = 1'b0;
    waddr_d  = waddr_q;
    spi_we_s = 1'b0;
    if (bus.ss) begin
      // Deselect discards any frame completing in this cycle.
      tx_d = STATUS_WORD;
    end else begin
      case (state_q)
        ST_IDLE: tx_d = STATUS_WORD;
        ST_CMD: begin
          if (frame_evt_s) begin
            ptr_d = cmd_addr_s;
            if (cmd_wr_s) tx_d = STATUS_WORD;
            else          tx_d = rd_data_s;
          end else begin
            tx_d = tx_q;
          end
        end
        ST_WRITE: begin
          tx_d = STATUS_WORD;
          if (frame_evt_s) begin
            spi_we_s = 1'b1;
            strobe_d = 1'b1;
            waddr_d  = ptr_q;
            ptr_d    = ptr_q + PTR_ONE;
          end else begin
            spi_we_s = 1'b0;
          end
        end
        ST_READ: begin
          if (frame_evt_s) begin
            ptr_d = ptr_q + PTR_ONE;
            tx_d  = rd_data_s;
          end else begin
            tx_d = tx_q;
          end
        end
        default: tx_d = STATUS_WORD;
      endcase
    end
  end

  // Registered datapath outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= {ADDR_W{1'b0}};
      tx_q     <= STATUS_WORD;
      strobe_q <= 1'b0;
      waddr_q  <= {ADDR_W{1'b0}};
    end else begin
      ptr_q    <= ptr_d;
      tx_q     <= tx_d;
      strobe_q <= strobe_d;
      waddr_q  <= waddr_d;
    end
  end

  spi_reg_file #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_reg_file (
    .clk          (clk),
    .reset        (reset),
    .spi_we_i     (spi_we_s),
    .spi_addr_i   (ptr_q),
    .spi_wdata_i  (bus.rx_data),
    .host_we_i    (bus.host_we),
    .host_addr_i  (bus.host_addr),
    .host_wdata_i (bus.host_wdata),
    .rd_addr_i    (rd_addr_s),
    .rd_data_o    (rd_data_s),
    .host_rdata_o (bus.host_rdata)
  );

  assign bus.tx_data       = tx_q;
  assign bus.spi_wr_strobe = strobe_q;
  assign bus.spi_wr_addr   = waddr_q;

endmodule

// File: tb/tb_spi_slave_reg_bridge.sv
// Scoreboard bench for spi_slave_reg_bridge: stimulus pushes expected MISO
// words, host read values and write-strobe addresses into queues; one
// monitor pops and compares when the corresponding output is presented.
module tb_spi_slave_reg_bridge;

  logic clk;
  logic reset;

  spi_slave_reg_bridge_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  spi_slave_reg_bridge #(
    .DATA_W      (8),
    .ADDR_W      (4),
    .STATUS_WORD (8'hA5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] exp_miso [$];
  logic [7:0] exp_host [$];
  logic [3:0] exp_strb [$];
  logic       miso_chk;
  logic       host_chk;
  logic       end_chk;
  int         vectors;
  int         miscompares;

  // Monitor: compare presented outputs against the queued expectations.
  always @(negedge clk) begin
    logic [7:0] e8;
    logic [3:0] e4;
    if (miso_chk) begin
      vectors++;
      if (exp_miso.size() == 0) begin
        miscompares++;
        $display("FAIL miso: got %h, no expectation queued", bus.tx_data);
      end else begin
        e8 = exp_miso.pop_front();
        if (bus.tx_data !== e8) begin
          miscompares++;
          $display("FAIL miso: got %h expected %h", bus.tx_data, e8);
        end
      end
    end
    if (host_chk) begin
      vectors++;
      if (exp_host.size() == 0) begin
        miscompares++;
        $display("FAIL host_rdata: got %h, no expectation queued", bus.host_rdata);
      end else begin
        e8 = exp_host.pop_front();
        if (bus.host_rdata !== e8) begin
          miscompares++;
          $display("FAIL host_rdata[%0d]: got %h expected %h", bus.host_addr, bus.host_rdata, e8);
        end
      end
    end
    if (bus.spi_wr_strobe === 1'b1) begin
      vectors++;
      if (exp_strb.size() == 0) begin
        miscompares++;
        $display("FAIL strobe: unexpected write strobe at addr %0d", bus.spi_wr_addr);
      end else begin
        e4 = exp_strb.pop_front();
        if (bus.spi_wr_addr !== e4) begin
          miscompares++;
          $display("FAIL strobe_addr: got %0d expected %0d", bus.spi_wr_addr, e4);
        end
      end
    end
    if (end_chk) begin
      vectors++;
      if ((exp_miso.size() + exp_host.size() + exp_strb.size()) != 0) begin
        miscompares++;
        $display("FAIL leftover: got %0d unconsumed expectations expected 0",
                 exp_miso.size() + exp_host.size() + exp_strb.size());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_tx(input logic [7:0] e);
    exp_miso.push_back(e);
    miso_chk = 1'b1;
    tick();
    miso_chk = 1'b0;
  endtask

  task automatic check_reg(input logic [3:0] a, input logic [7:0] e);
    bus.host_addr = a;
    exp_host.push_back(e);
    host_chk = 1'b1;
    tick();
    host_chk = 1'b0;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    bus.host_addr  = a;
    bus.host_wdata = d;
    bus.host_we    = 1'b1;
    tick();
    bus.host_we    = 1'b0;
  endtask

  task automatic ss_low();
    bus.ss = 1'b0;
    repeat (2) tick();
  endtask

  task automatic ss_high();
    bus.ss = 1'b1;
    repeat (2) tick();
  endtask

  // One SPI frame: MISO word is sampled at frame start, rx_done is held
  // two cycles; optional host write and/or deselect in the frame_evt cycle.
  task automatic frame(input logic [7:0] rx, input logic [7:0] miso,
                       input logic hwe, input logic [3:0] ha,
                       input logic [7:0] hd, input logic kill);
    check_tx(miso);
    repeat (6) tick();
    bus.rx_data = rx;
    bus.rx_done = 1'b1;
    if (hwe) begin
      bus.host_addr  = ha;
      bus.host_wdata = hd;
      bus.host_we    = 1'b1;
    end
    if (kill) bus.ss = 1'b1;
    tick();
    bus.host_we = 1'b0;
    tick();
    bus.rx_done = 1'b0;
    tick();
  endtask

  task automatic fr(input logic [7:0] rx, input logic [7:0] miso);
    frame(rx, miso, 1'b0, 4'd0, 8'h00, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    miso_chk    = 1'b0;
    host_chk    = 1'b0;
    end_chk     = 1'b0;
    reset          = 1'b1;
    bus.ss         = 1'b1;
    bus.rx_data    = 8'h00;
    bus.rx_done    = 1'b0;
    bus.host_addr  = 4'd0;
    bus.host_we    = 1'b0;
    bus.host_wdata = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state.
    check_tx(8'hA5);
    for (int i = 0; i < 16; i++) check_reg(4'(i), 8'h00);

    // Write burst at 3.
    ss_low();
    exp_strb.push_back(4'd3);
    exp_strb.push_back(4'd4);
    fr(8'h83, 8'hA5);
    fr(8'h11, 8'hA5);
    fr(8'h22, 8'hA5);
    ss_high();
    check_reg(4'd3, 8'h11);
    check_reg(4'd4, 8'h22);
    check_tx(8'hA5);

    // Read burst at 7 after a host write.
    host_write(4'd7, 8'h5C);
    ss_low();
    fr(8'h07, 8'hA5);
    fr(8'h00, 8'h5C);
    fr(8'h00, 8'h00);
    ss_high();
    check_tx(8'hA5);

    // Write burst wrapping 15 -> 0.
    ss_low();
    exp_strb.push_back(4'd15);
    exp_strb.push_back(4'd0);
    fr(8'h8F, 8'hA5);
    fr(8'hAA, 8'hA5);
    fr(8'hBB, 8'hA5);
    ss_high();
    check_reg(4'd15, 8'hAA);
    check_reg(4'd0, 8'hBB);

    // Same-cycle SPI and host writes: same address, then different.
    ss_low();
    exp_strb.push_back(4'd2);
    exp_strb.push_back(4'd3);
    fr(8'h82, 8'hA5);
    frame(8'h33, 8'hA5, 1'b1, 4'd2, 8'h44, 1'b0);
    frame(8'h77, 8'hA5, 1'b1, 4'd9, 8'h99, 1'b0);
    ss_high();
    check_reg(4'd2, 8'h33);
    check_reg(4'd3, 8'h77);
    check_reg(4'd9, 8'h99);

    // Read command sees a host write in its frame_evt cycle.
    ss_low();
    frame(8'h09, 8'hA5, 1'b1, 4'd9, 8'h5A, 1'b0);
    fr(8'h00, 8'h5A);
    ss_high();
    check_reg(4'd9, 8'h5A);

    // Deselect coincident with a data frame: frame dropped.
    ss_low();
    fr(8'h81, 8'hA5);
    frame(8'h77, 8'hA5, 1'b0, 4'd0, 8'h00, 1'b1);
    repeat (2) tick();
    check_reg(4'd1, 8'h00);
    check_tx(8'hA5);

    // Deselect mid data frame, without rx_done.
    ss_low();
    fr(8'h83, 8'hA5);
    check_tx(8'hA5);
    repeat (3) tick();
    ss_high();
    check_reg(4'd3, 8'h77);

    // Empty select window.
    ss_low();
    repeat (4) tick();
    ss_high();
    check_reg(4'd3, 8'h77);

    // Reset in the middle of a write burst.
    ss_low();
    exp_strb.push_back(4'd10);
    fr(8'h8A, 8'hA5);
    fr(8'h12, 8'hA5);
    check_reg(4'd10, 8'h12);
    check_tx(8'hA5);
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    bus.ss = 1'b1;
    reset  = 1'b0;
    tick();
    check_tx(8'hA5);
    for (int i = 0; i < 16; i++) check_reg(4'(i), 8'h00);

    end_chk = 1'b1;
    tick();
    end_chk = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
